// File: rtl/ieee_fp32_multiplier.sv
// IEEE-754 binary32 multiplier, round-to-nearest-even, subnormals flushed to zero.
// One combinational multiply/normalise/round stage feeding a single output register.
module ieee_fp32_multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] number1,
    input  logic [31:0] number2,
    output logic [31:0] result
);

    // Operand fields
    logic        sa, sb, sr;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;

    assign sa = number1[31];
    assign ea = number1[30:23];
    assign fa = number1[22:0];
    assign sb = number2[31];
    assign eb = number2[30:23];
    assign fb = number2[22:0];
    assign sr = sa ^ sb;

    // Class decode; exp==0 is treated as zero regardless of fraction (DAZ)
    logic zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;

    assign zero_a = (ea == 8'h00);
    assign zero_b = (eb == 8'h00);
    assign inf_a  = (ea == 8'hFF) && (fa == 23'h0);
    assign inf_b  = (eb == 8'hFF) && (fb == 23'h0);
    assign nan_a  = (ea == 8'hFF) && (fa != 23'h0);
    assign nan_b  = (eb == 8'hFF) && (fb != 23'h0);

    // Significand product with hidden ones; full 48-bit width so no bits are lost
    logic [47:0] mant_a, mant_b, prod;

    assign mant_a = {24'd0, 1'b1, fa};
    assign mant_b = {24'd0, 1'b1, fb};
    assign prod   = mant_a * mant_b;

    // Exponent sum kept signed at 10 bits so both overflow and underflow stay visible
    logic signed [9:0] exp_sum;

    assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;

    // Normalise: the product of two [1,2) values lies in [1,4), so at most one shift
    logic [23:0]       sig;
    logic              guard, sticky;
    logic signed [9:0] exp_n;

    // Pick the 24-bit window below the leading one and collect guard/sticky
    always_comb begin
        sig    = prod[46:23];
        guard  = prod[22];
        sticky = |prod[21:0];
        exp_n  = exp_sum;
        if (prod[47]) begin
            sig    = prod[47:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            exp_n  = exp_sum + 10'sd1;
        end
    end

    // Round to nearest, ties to even
    logic              rnd_inc;
    logic [24:0]       sig_rnd;
    logic [22:0]       frac_f;
    logic signed [9:0] exp_f;

    assign rnd_inc = guard && (sticky || sig[0]);
    assign sig_rnd = {1'b0, sig} + {24'd0, rnd_inc};

    // A carry out of the rounder means the significand became 1.000..0 x 2
    always_comb begin
        frac_f = sig_rnd[22:0];
        exp_f  = exp_n;
        if (sig_rnd[24]) begin
            frac_f = sig_rnd[23:1];
            exp_f  = exp_n + 10'sd1;
        end
    end

    // Special cases first in priority order, then range checks on the rounded result
    logic [31:0] result_d;

    always_comb begin
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a))
            result_d = 32'h7FC0_0000;
        else if (inf_a || inf_b)
            result_d = {sr, 8'hFF, 23'h0};
        else if (zero_a || zero_b)
            result_d = {sr, 31'h0};
        else if (exp_f >= 10'sd255)
            result_d = {sr, 8'hFF, 23'h0};
        else if (exp_f <= 10'sd0)
            result_d = {sr, 31'h0};
        else
            result_d = {sr, exp_f[7:0], frac_f};
    end

    // Output register; reset clears any in-flight product
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            result <= 32'h0000_0000;
        else
            result <= result_d;
    end

endmodule

// File: tb/tb_ieee_fp32_multiplier.sv
// Scoreboard bench for ieee_fp32_multiplier: directed spec vectors, latency/reset
// behaviour, and randomized operands checked against an integer-arithmetic model.
module tb_ieee_fp32_multiplier;

    logic        clk;
    logic        rst;
    logic [31:0] number1, number2;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } txn_t;

    txn_t exp_q[$];
    bit   mon_en = 1'b0;

    ieee_fp32_multiplier dut (
        .clk     (clk),
        .rst     (rst),
        .number1 (number1),
        .number2 (number2),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer product, rounded by comparing the discarded remainder to half
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          ea, eb, e, sh, msb;
        longint      ma, mb, p, q, rem, half;
        logic [63:0] qb;
        bit          za, zb, ia, ib, na, nb;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        if (na || nb || (ia && zb) || (ib && za)) return 32'h7FC0_0000;
        if (ia || ib) return {s, 8'hFF, 23'h0};
        if (za || zb) return {s, 31'h0};
        ma  = longint'(a[22:0]) + (64'sd1 << 23);
        mb  = longint'(b[22:0]) + (64'sd1 << 23);
        p   = ma * mb;
        msb = (p >= (64'sd1 << 47)) ? 47 : 46;
        sh  = msb - 23;
        q   = p >>> sh;
        rem = p - (q <<< sh);
        half = 64'sd1 <<< (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        e = ea + eb - 127 + (msb - 46);
        if (q >= (64'sd1 << 24)) begin
            q = q >>> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        qb = q;
        return {s, e[7:0], qb[22:0]};
    endfunction

    function automatic logic [31:0] rand_normal();
        logic [31:0] v;
        v = $urandom;
        v[30:23] = 8'($urandom_range(1, 254));
        return v;
    endfunction

    function automatic logic [31:0] rand_any();
        logic [31:0] v;
        int sel;
        v   = rand_normal();
        sel = $urandom_range(0, 9);
        if (sel == 0) v[30:23] = 8'h00;
        else if (sel == 1) v[30:23] = 8'hFF;
        else if (sel == 2) begin
            v[30:23] = 8'hFF;
            v[22:0]  = 23'h0;
        end
        return v;
    endfunction

    // Drive operands away from the active edge and queue the expected product
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        @(negedge clk);
        number1 = a;
        number2 = b;
        exp_q.push_back('{a: a, b: b, exp: e});
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Monitor: one product is due after every rising edge following an issue
    always @(posedge clk) begin
        #1;
        if (mon_en && exp_q.size() > 0) begin
            txn_t t;
            t = exp_q.pop_front();
            checks++;
            if (result !== t.exp) begin
                errors++;
                $display("FAIL prod %h*%h got %h want %h", t.a, t.b, result, t.exp);
            end
        end
    end

    initial begin
        rst     = 1'b1;
        number1 = 32'h0;
        number2 = 32'h0;
        #1;
        check("reset", result, 32'h0);
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Directed vectors with hand-derived expectations
        issue(32'h40ADD2F2, 32'h4016147B, 32'h414BCF04);
        issue(32'h3F800000, 32'hC0490FDB, 32'hC0490FDB);
        issue(32'h40000000, 32'h40400000, 32'h40C00000);
        issue(32'h7F800000, 32'h00000000, 32'h7FC00000);
        issue(32'h00000000, 32'hFF800000, 32'h7FC00000);
        issue(32'hFF800000, 32'h40000000, 32'hFF800000);
        issue(32'h7FC00001, 32'h3F800000, 32'h7FC00000);
        issue(32'h7F7FFFFF, 32'h40000000, 32'h7F800000);
        issue(32'h00800000, 32'h00800000, 32'h00000000);
        issue(32'h80000000, 32'h3F800000, 32'h80000000);
        issue(32'h007FFFFF, 32'hC0000000, 32'h80000000);
        issue(32'h3FFFFFFF, 32'h3F800001, 32'h40000000);

        // Latency: change A only, then B only; output must hold until the next edge
        issue(32'h40000000, 32'h40400000, 32'h40C00000);
        @(negedge clk);
        number1 = 32'h3F800000;
        exp_q.push_back('{a: 32'h3F800000, b: 32'h40400000, exp: 32'h40400000});
        #1;
        check("hold_after_a", result, 32'h40C00000);
        @(negedge clk);
        number2 = 32'h40000000;
        exp_q.push_back('{a: 32'h3F800000, b: 32'h40000000, exp: 32'h40000000});
        #1;
        check("hold_after_b", result, 32'h40400000);
        repeat (2) @(negedge clk);

        // Mid-stream asynchronous reset
        mon_en  = 1'b0;
        exp_q.delete();
        number1 = 32'h40000000;
        number2 = 32'h40400000;
        @(posedge clk);
        #1;
        check("pre_rst", result, 32'h40C00000);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", result, 32'h0);
        @(posedge clk);
        #1;
        check("rst_hold", result, 32'h0);
        @(negedge clk);
        rst     = 1'b0;
        number1 = 32'h3F800000;
        number2 = 32'hC0490FDB;
        #1;
        check("rst_released", result, 32'h0);
        @(posedge clk);
        #1;
        check("post_rst", result, 32'hC0490FDB);
        mon_en = 1'b1;

        // Randomized normal operands, then a mix including zeros, infs and NaNs
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] a, b;
            a = rand_normal();
            b = rand_normal();
            issue(a, b, ref_mul(a, b));
        end
        for (int i = 0; i < 500; i++) begin
            logic [31:0] a, b;
            a = rand_any();
            b = rand_any();
            issue(a, b, ref_mul(a, b));
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
